serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: diff = A - B, one bit per clock, LSB first.
//   A single borrow cell is reused; it is the subtract counterpart of the FA/HA adder cells.
//   A down-counter sequences the cell through WIDTH cycles.

---
 rtl/serial_subtractor.sv | 156 +++++++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = A - B), one bit per clock, LSB first.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic             done_q, done_d;

  // Single borrow cell, reused every RUN cycle.
  logic bit_a, bit_b, bit_d, bit_bout;

  always_comb begin
    bit_a    = a_sh_q[0];
    bit_b    = b_sh_q[0];
    bit_d    = bit_a ^ bit_b ^ borrow_q;
    bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d    = {bit_d, res_q[WIDTH-1:1]};
        borrow_d = bit_bout;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        diff_d       = res_q;
        borrow_out_d = borrow_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep copies for the overflow test.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start) begin
      a_msb_d = A[WIDTH-1];
      b_msb_d = B[WIDTH-1];
    end
    if (state_q == DONE) begin
      ovf_d = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8; WIDTH=2 as well with SERIAL_SUB_OVF_EN).
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_L;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, borrow_out;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
  logic             start2;
  logic [1:0]       A2, B2, diff2;
  logic             busy2, done2, borrow2, ovf2;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

`ifdef SERIAL_SUB_OVF_EN
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk        (clk),
    .reset_L    (reset_L),
    .start      (start2),
    .A          (A2),
    .B          (B2),
    .busy       (busy2),
    .done       (done2),
    .diff       (diff2),
    .borrow_out (borrow2),
    .ovf        (ovf2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // inj >= 0 pulses a competing start (A=0x77, B=0x11) at that RUN observation index.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                        input logic eb, input logic eo, input int inj);
    logic [7:0] diff0;
    int         cyc;
    int         bcnt;
    logic       toggled;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    diff0   = diff;
    cyc     = 0;
    bcnt    = 0;
    toggled = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      if (diff !== diff0) toggled = 1'b1;
      if (cyc == inj) begin
        start = 1'b1;
        A = 8'h77;
        B = 8'h11;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(WIDTH + 1));
    chk("busy_cycles", 32'(bcnt), 32'(WIDTH));
    chk("diff_stable_in_run", 32'(toggled), 32'd0);
    chk("diff", 32'(diff), 32'(ed));
    chk("borrow_out", 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf), 32'(eo));
`endif
    $display("op A=0x%02h B=0x%02h -> diff=0x%02h borrow_out=%0b (expect 0x%02h/%0b/ovf %0b) cycles=%0d",
             a, b, diff, borrow_out, ed, eb, eo, cyc);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic flag;
    reset_L = 1'b0;
    start   = 1'b0;
    A       = '0;
    B       = '0;
`ifdef SERIAL_SUB_OVF_EN
    start2  = 1'b0;
    A2      = '0;
    B2      = '0;
`endif
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    reset_L = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, -1);

    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, -1);
    repeat (4) tick();
    chk("hold_diff", 32'(diff), 32'hF0);
    chk("hold_borrow", 32'(borrow_out), 32'd1);

    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, -1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, -1);

    run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 2);
    flag = 1'b0;
    repeat (12) begin
      if (done === 1'b1 || busy === 1'b1) flag = 1'b1;
      tick();
    end
    chk("ignored_start_no_rerun", 32'(flag), 32'd0);

    A = 8'h80;
    B = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_diff", 32'(diff), 32'd0);
    chk("async_rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("async_rst_ovf", 32'(ovf), 32'd0);
`endif
    $display("reset asserted mid-run: busy=%0b done=%0b diff=0x%02h", busy, done, diff);
    tick();
    tick();
    reset_L = 1'b1;
    flag = 1'b0;
    repeat (12) begin
      if (done === 1'b1 || busy === 1'b1) flag = 1'b1;
      tick();
    end
    chk("no_done_after_reset", 32'(flag), 32'd0);
    run_op(8'h03, 8'h02, 8'h01, 1'b0, 1'b0, -1);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, -1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, -1);
    begin
      int cyc;
      A2 = 2'b01;
      B2 = 2'b10;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      cyc = 0;
      while (done2 !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("w2_latency", 32'(cyc), 32'd3);
      chk("w2_diff", 32'(diff2), 32'd3);
      chk("w2_borrow", 32'(borrow2), 32'd1);
      chk("w2_ovf", 32'(ovf2), 32'd1);
      $display("op W2 A=01 B=10 -> diff=%02b borrow_out=%0b ovf=%0b", diff2, borrow2, ovf2);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
